// File: rtl/wb_pipe_mem_if.sv
// wb_pipe_mem_if: pipelined Wishbone bus bundle between one master and one
// responder. Signal names are written from the responder's point of view
// (_i driven by the master, _o driven by the responder).
//   cyc_i    bus cycle active
//   stb_i    request strobe
//   we_i     1 = write, 0 = read
//   sel_i    byte enables, sel_i[3] covers dat_i[31:24]
//   adr_i    byte address
//   dat_i    write data
//   dat_o    read data, zero unless ack_o
//   ack_o    one-cycle acknowledge per accepted request
//   stall_o  request not accepted this cycle
interface wb_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        stall_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  dat_o, ack_o, stall_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output dat_o, ack_o, stall_o
    );
endinterface

// File: rtl/wb_pipe_mem.sv
// wb_pipe_mem: pipelined Wishbone responder backed by a word-addressed RAM.
// Accepts at most one request per cycle, acknowledges in order exactly
// LATENCY cycles after acceptance, and stalls when MAX_OUT requests are
// outstanding or when the stall_inject test hook is high.
//   clk_i         clock
//   rst_i         synchronous active-high reset (RAM contents preserved)
//   bus           wb_if slave modport (cyc/stb/we/sel/adr/dat in, dat/ack/stall out)
//   stall_inject  forces stall_o high
//
// Occupancy states, all derived from the outstanding counter:
//   state | meaning
//   IDLE  | out_cnt_q == 0
//   BUSY  | 0 < out_cnt_q < MAX_OUT
//   FULL  | out_cnt_q == MAX_OUT, stall_o asserted
// IDLE is re-entered from any state on rst_i or a cycle with cyc_i low.
module wb_pipe_mem #(
    parameter int AWIDTH    = 12,
    parameter int LATENCY   = 2,
    parameter int MAX_OUT   = 4,
    parameter     INIT_FILE = ""
) (
    input  logic clk_i,
    input  logic rst_i,
    wb_if.slave  bus,
    input  logic stall_inject
);
    localparam int         DEPTH     = 1 << AWIDTH;
    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

    logic [31:0]        mem_q [DEPTH];
    logic [3:0]         out_cnt_q;
    logic [3:0]         out_cnt_d;
    logic [LATENCY-1:0] pv_q;
    logic [31:0]        pd_q [LATENCY];
    logic [AWIDTH-1:0]  word_idx;
    logic               accept;
    logic               ack;

    // Upper address bits are ignored, so the word index wraps naturally.
    assign word_idx    = bus.adr_i[AWIDTH+1:2];

    // Depends only on registered occupancy and the test hook, never on stb_i.
    assign bus.stall_o = stall_inject | (out_cnt_q == MAX_OUT_C);
    assign accept      = bus.cyc_i & bus.stb_i & ~bus.stall_o;

    // Gating with cyc_i hides the last pipe stage during the cycle the
    // master abandons; the flush itself happens at the following edge.
    assign ack         = bus.cyc_i & pv_q[LATENCY-1];
    assign bus.ack_o   = ack;
    assign bus.dat_o   = ack ? pd_q[LATENCY-1] : '0;

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({accept, ack})
            2'b10:   out_cnt_d = out_cnt_q + 4'd1;
            2'b01:   out_cnt_d = out_cnt_q - 4'd1;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !bus.cyc_i) begin
            out_cnt_q <= '0;
            pv_q      <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                pd_q[s] <= '0;
            end
        end else begin
            out_cnt_q <= out_cnt_d;
            pv_q[0]   <= accept;
            // Writes carry zero data so the ack path needs no write/read mux.
            pd_q[0]   <= (accept && !bus.we_i) ? mem_q[word_idx] : '0;
            for (int s = 1; s < LATENCY; s++) begin
                pv_q[s] <= pv_q[s-1];
                pd_q[s] <= pd_q[s-1];
            end
        end
    end

    // RAM has no reset: contents survive rst_i and cyc_i drops.
    always_ff @(posedge clk_i) begin
        if (accept && bus.we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.sel_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= bus.dat_i[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_pipe_mem.sv
// tb_wb_pipe_mem: three responders with different LATENCY/MAX_OUT settings
// share one clock. A queue-of-due-times reference model predicts stall_o,
// ack_o and dat_o for every DUT in every cycle; a directed vector table and
// hand-written sequences cover the multi-cycle corner cases.
`timescale 1ns/1ps
module tb_wb_pipe_mem;
    localparam int NDUT  = 3;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    function automatic int lat_of(int d);
        case (d)
            0:       return 2;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int maxo_of(int d);
        case (d)
            0:       return 4;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [NDUT];
    logic        cyc   [NDUT];
    logic        stb   [NDUT];
    logic        we    [NDUT];
    logic        inj   [NDUT];
    logic [3:0]  sel   [NDUT];
    logic [31:0] adr   [NDUT];
    logic [31:0] wdat  [NDUT];
    logic        ack_w [NDUT];
    logic        stall_w [NDUT];
    logic [31:0] rdat_w  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        wb_if bus ();
        assign bus.cyc_i = cyc[g];
        assign bus.stb_i = stb[g];
        assign bus.we_i  = we[g];
        assign bus.sel_i = sel[g];
        assign bus.adr_i = adr[g];
        assign bus.dat_i = wdat[g];
        assign ack_w[g]   = bus.ack_o;
        assign stall_w[g] = bus.stall_o;
        assign rdat_w[g]  = bus.dat_o;

        wb_pipe_mem #(
            .AWIDTH   (AW),
            .LATENCY  (lat_of(g)),
            .MAX_OUT  (maxo_of(g)),
            .INIT_FILE("")
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst[g]),
            .bus         (bus),
            .stall_inject(inj[g])
        );
    end

    // Reference model: RAM image plus an in-order queue of (due cycle, data).
    logic [31:0] mem_m [NDUT][DEPTH];
    int          q_due [NDUT][16];
    logic [31:0] q_dat [NDUT][16];
    int          q_hd  [NDUT];
    int          q_n   [NDUT];
    logic        stall_s [NDUT];
    int          cnum;
    int          n_pass;
    int          n_total;
    int          cap_d;
    logic [31:0] cap_dat [$];
    int          cap_cyc [$];

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [11];
    int   acc [11];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cnum);
    endtask

    task automatic timeout(string name);
        n_total++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cnum);
    endtask

    task automatic model_step(int d);
        logic        e_stall;
        logic        e_ack;
        logic [31:0] e_dat;
        logic [31:0] rd;
        int          idx;
        e_stall = inj[d] || (q_n[d] == maxo_of(d));
        e_ack   = cyc[d] && (q_n[d] > 0) && (q_due[d][q_hd[d]] == cnum);
        e_dat   = e_ack ? q_dat[d][q_hd[d]] : 32'h0;
        if (!rst[d]) begin
            chk($sformatf("d%0d stall", d), {31'h0, stall_w[d]}, {31'h0, e_stall});
            chk($sformatf("d%0d ack", d),   {31'h0, ack_w[d]},   {31'h0, e_ack});
            chk($sformatf("d%0d dat", d),   rdat_w[d], e_dat);
            if (d == cap_d && ack_w[d] === 1'b1) begin
                cap_dat.push_back(rdat_w[d]);
                cap_cyc.push_back(cnum);
            end
        end
        stall_s[d] = stall_w[d];
        if (e_ack) begin
            q_hd[d] = (q_hd[d] + 1) % 16;
            q_n[d]  = q_n[d] - 1;
        end
        if (!rst[d] && cyc[d] && stb[d] && !e_stall) begin
            idx = int'(adr[d][AW+1:2]);
            rd  = we[d] ? 32'h0 : mem_m[d][idx];
            if (we[d]) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel[d][b]) mem_m[d][idx][8*b +: 8] = wdat[d][8*b +: 8];
                end
            end
            q_due[d][(q_hd[d] + q_n[d]) % 16] = cnum + lat_of(d);
            q_dat[d][(q_hd[d] + q_n[d]) % 16] = rd;
            q_n[d] = q_n[d] + 1;
        end
        if (rst[d] || !cyc[d]) q_n[d] = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) model_step(d);
        cnum++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int d, logic w, logic [3:0] s, logic [31:0] a,
                         logic [31:0] dt, output int acc_cyc);
        int c0;
        int tries;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
        sel[d] = s;    adr[d] = a;    wdat[d] = dt;
        acc_cyc = -1;
        tries = 0;
        while (acc_cyc < 0 && tries < 100) begin
            c0 = cnum;
            cycle();
            if (stall_s[d] === 1'b0) acc_cyc = c0;
            tries++;
        end
        if (acc_cyc < 0) timeout($sformatf("d%0d accept", d));
    endtask

    task automatic idle(int d);
        stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0;
    endtask

    task automatic drain(int d);
        int tries;
        idle(d);
        tries = 0;
        while (q_n[d] > 0 && tries < 40) begin
            cycle();
            tries++;
        end
        if (q_n[d] > 0) timeout($sformatf("d%0d drain", d));
        cycle();
    endtask

    task automatic clear_cap(int d);
        cap_d = d;
        cap_dat.delete();
        cap_cyc.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        cnum = 0; n_pass = 0; n_total = 0; cap_d = -1;
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            inj[d] = 1'b0; sel[d] = 4'h0; adr[d] = 32'h0; wdat[d] = 32'h0;
            q_hd[d] = 0; q_n[d] = 0; stall_s[d] = 1'b0;
        end
        @(posedge clk); #1;
        cycle();
        cycle();
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
        cycle();
        inj[0] = 1'b1;
        cycle();
        inj[0] = 1'b0;

        // Preload word n = 0x1000_0000 + n through the bus.
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < DEPTH; n++) issue(d, 1'b1, 4'hF, 32'(n * 4), 32'h1000_0000 + 32'(n), a);
            drain(d);
        end

        // Directed table: back-to-back requests, byte-lane writes, wrap.
        tbl[0]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,          32'h1000_0000};
        tbl[1]  = '{1'b0, 4'h0, 32'h0000_0004, 32'h0,          32'h1000_0001};
        tbl[2]  = '{1'b0, 4'h0, 32'h0000_0008, 32'h0,          32'h1000_0002};
        tbl[3]  = '{1'b0, 4'h0, 32'h0000_000C, 32'h0,          32'h1000_0003};
        tbl[4]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0};
        tbl[5]  = '{1'b1, 4'h3, 32'h0000_0010, 32'hAABB_CCDD, 32'h0};
        tbl[6]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,          32'h1122_CCDD};
        tbl[7]  = '{1'b1, 4'h0, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0};
        tbl[8]  = '{1'b0, 4'h0, 32'h0000_0014, 32'h0,          32'h1000_0005};
        tbl[9]  = '{1'b0, 4'h0, 32'h0000_0400, 32'h0,          32'h1000_0000};
        tbl[10] = '{1'b0, 4'h0, 32'hFFFF_F404, 32'h0,          32'h1000_0001};
        clear_cap(0);
        for (int i = 0; i < 11; i++) issue(0, tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].wdat, acc[i]);
        drain(0);
        chk("tbl ack count", 32'(cap_dat.size()), 32'd11);
        for (int i = 0; i < 11 && i < cap_dat.size(); i++) begin
            chk($sformatf("tbl[%0d] dat", i), cap_dat[i], tbl[i].exp);
            chk($sformatf("tbl[%0d] ack cycle", i), 32'(cap_cyc[i]), 32'(acc[i] + 2));
            chk($sformatf("tbl[%0d] no stall", i), 32'(acc[i]), 32'(acc[0] + i));
        end

        // LATENCY=4, MAX_OUT=2: third request waits for the first ack.
        clear_cap(1);
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 4'h0, 32'(i * 4), 32'h0, acc[i]);
        drain(1);
        chk("l4 ack count", 32'(cap_dat.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap_dat.size(); i++)
            chk($sformatf("l4 dat[%0d]", i), cap_dat[i], 32'h1000_0000 + 32'(i));
        chk("l4 2nd accept", 32'(acc[1]), 32'(acc[0] + 1));
        if (cap_cyc.size() > 0) begin
            chk("l4 first ack", 32'(cap_cyc[0]), 32'(acc[0] + 4));
            chk("l4 3rd accept", 32'(acc[2]), 32'(cap_cyc[0] + 1));
        end

        // stall_inject holds off a pending request for three cycles.
        clear_cap(0);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h20;
        inj[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("inject stall", {31'h0, stall_s[0]}, 32'h1);
        end
        chk("inject no ack", 32'(cap_dat.size()), 32'd0);
        inj[0] = 1'b0;
        for (int i = 0; i < 3; i++) issue(0, 1'b0, 4'h0, 32'h20 + 32'(i * 4), 32'h0, acc[i]);
        drain(0);
        chk("inject ack count", 32'(cap_dat.size()), 32'd3);
        for (int i = 0; i < 3 && i < cap_dat.size(); i++)
            chk($sformatf("inject dat[%0d]", i), cap_dat[i], 32'h1000_0008 + 32'(i));

        // cyc_i drop with two reads outstanding discards them.
        clear_cap(1);
        issue(1, 1'b0, 4'h0, 32'h30, 32'h0, acc[0]);
        issue(1, 1'b0, 4'h0, 32'h34, 32'h0, acc[1]);
        idle(1);
        cyc[1] = 1'b0;
        cycle();
        cyc[1] = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("cyc drop no ack", 32'(cap_dat.size()), 32'd0);
        chk("cyc drop stall", {31'h0, stall_s[1]}, 32'h0);

        // Reset mid-burst on the LATENCY=3 instance.
        clear_cap(2);
        for (int i = 0; i < 3; i++) issue(2, 1'b0, 4'h0, 32'(i * 4), 32'h0, acc[i]);
        idle(2);
        rst[2] = 1'b1;
        cycle();
        rst[2] = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("reset no ack", 32'(cap_dat.size()), 32'd0);
        issue(2, 1'b0, 4'h0, 32'h8, 32'h0, acc[0]);
        drain(2);
        chk("reset new ack count", 32'(cap_dat.size()), 32'd1);
        if (cap_dat.size() > 0) begin
            chk("reset new dat", cap_dat[0], 32'h1000_0002);
            chk("reset new latency", 32'(cap_cyc[0]), 32'(acc[0] + 3));
        end

        // Random traffic on all instances, checked every cycle by the model.
        cap_d = -1;
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < NDUT; d++) begin
                cyc[d]  = ($urandom_range(0, 19) != 0);
                stb[d]  = $urandom_range(0, 1) == 1;
                we[d]   = ($urandom_range(0, 3) == 0);
                sel[d]  = 4'($urandom);
                adr[d]  = $urandom;
                wdat[d] = $urandom;
                inj[d]  = ($urandom_range(0, 9) == 0);
            end
            cycle();
        end
        for (int d = 0; d < NDUT; d++) begin
            inj[d] = 1'b0;
            cyc[d] = 1'b1;
            drain(d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
